// File: rtl/lane_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lane_mem_arbiter
// Brief    : Round-robin arbiter sharing one data-memory port among lane LSUs.
//            Optional watchdog enabled by defining LANE_MEM_ARBITER_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module lane_mem_arbiter #(
   parameter int NUM_LANES      = 4,
   parameter int ADDR_WIDTH     = 7,
   parameter int DATA_WIDTH     = 64,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_LANES-1:0]             lane_read_valid,
   input  logic [NUM_LANES-1:0]             lane_write_valid,
   input  logic [NUM_LANES*ADDR_WIDTH-1:0]  lane_read_addr,
   input  logic [NUM_LANES*ADDR_WIDTH-1:0]  lane_write_addr,
   input  logic [NUM_LANES*DATA_WIDTH-1:0]  lane_write_data,
   output logic [NUM_LANES-1:0]             lane_read_ack,
   output logic [NUM_LANES-1:0]             lane_write_ack,
   output logic [NUM_LANES*DATA_WIDTH-1:0]  lane_read_data,
   output logic                             mem_read_valid,
   output logic [ADDR_WIDTH-1:0]            mem_read_addr,
   input  logic                             mem_read_ready,
   input  logic [DATA_WIDTH-1:0]            mem_read_data,
   output logic                             mem_write_valid,
   output logic [ADDR_WIDTH-1:0]            mem_write_addr,
   output logic [DATA_WIDTH-1:0]            mem_write_data,
   input  logic                             mem_write_ready,
`ifdef LANE_MEM_ARBITER_TIMEOUT_EN
   output logic                             timeout_err,
`endif
   output logic                             busy
);

   localparam int PTR_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ISSUE   = 2'd1;
   localparam logic [1:0] S_WAIT    = 2'd2;
   localparam logic [1:0] S_RESPOND = 2'd3;

   if (NUM_LANES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("lane_mem_arbiter: NUM_LANES must be >= 2 and TIMEOUT_CYCLES >= 1");
   end

   logic [1:0]                      r_state;
   logic [1:0]                      w_next;
   logic [PTR_W-1:0]                r_rr_ptr;
   logic [NUM_LANES-1:0]            r_armed;
   logic [NUM_LANES-1:0]            w_elig;
   logic [NUM_LANES-1:0]            w_ack;
   logic                            w_found;
   logic [PTR_W-1:0]                w_pick;
   logic [PTR_W-1:0]                r_lane;
   logic                            r_wr;
   logic [ADDR_WIDTH-1:0]           r_addr;
   logic [DATA_WIDTH-1:0]           r_data;
   logic [NUM_LANES*DATA_WIDTH-1:0] r_rdata;
   logic                            w_done;
   logic                            w_timeout;

   assign w_elig         = r_armed & (lane_read_valid | lane_write_valid);
   assign w_done         = r_wr ? mem_write_ready : mem_read_ready;
   assign w_ack          = lane_read_ack | lane_write_ack;
   assign mem_read_addr  = r_addr;
   assign mem_write_addr = r_addr;
   assign mem_write_data = r_data;
   assign lane_read_data = r_rdata;

   // First eligible lane at or after the round-robin pointer.
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      for (int k = 0; k < NUM_LANES; k++) begin
         if (!w_found && w_elig[(int'(r_rr_ptr) + k) % NUM_LANES]) begin
            w_found = 1'b1;
            w_pick  = PTR_W'((int'(r_rr_ptr) + k) % NUM_LANES);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (w_found) w_next = S_ISSUE;
         S_ISSUE:   w_next = S_WAIT;
         S_WAIT:    if (w_done || w_timeout) w_next = S_RESPOND;
         S_RESPOND: w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_comb begin
      mem_read_valid  = (r_state == S_WAIT) && !r_wr;
      mem_write_valid = (r_state == S_WAIT) &&  r_wr;
      busy            = (r_state != S_IDLE);
      lane_read_ack   = '0;
      lane_write_ack  = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         lane_read_ack[i]  = (r_state == S_RESPOND) && !r_wr && (r_lane == PTR_W'(i));
         lane_write_ack[i] = (r_state == S_RESPOND) &&  r_wr && (r_lane == PTR_W'(i));
      end
   end

   // Read wins when a lane raises both valids; its write waits for re-arm.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lane <= '0;
         r_wr   <= 1'b0;
         r_addr <= '0;
         r_data <= '0;
      end else if (r_state == S_IDLE && w_found) begin
         r_lane <= w_pick;
         r_wr   <= ~lane_read_valid[w_pick];
         r_addr <= lane_read_valid[w_pick] ? lane_read_addr[w_pick*ADDR_WIDTH +: ADDR_WIDTH]
                                           : lane_write_addr[w_pick*ADDR_WIDTH +: ADDR_WIDTH];
         r_data <= lane_write_data[w_pick*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rr_ptr <= '0;
         r_armed  <= '1;
      end else begin
         if (r_state == S_RESPOND)
            r_rr_ptr <= PTR_W'((int'(r_lane) + 1) % NUM_LANES);
         r_armed <= (r_armed | ~(lane_read_valid | lane_write_valid)) & ~w_ack;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_rdata <= '0;
      else if (r_state == S_WAIT && !r_wr && mem_read_ready)
         r_rdata[r_lane*DATA_WIDTH +: DATA_WIDTH] <= mem_read_data;
      else if (r_state == S_WAIT && !r_wr && w_timeout)
         r_rdata[r_lane*DATA_WIDTH +: DATA_WIDTH] <= '0;
   end

`ifdef LANE_MEM_ARBITER_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WD_W-1:0] r_wdog;
   logic            r_timeout_err;

   // Fires after TIMEOUT_CYCLES consecutive WAIT cycles with no ready.
   assign w_timeout   = (r_state == S_WAIT) && !w_done && (r_wdog == WD_W'(TIMEOUT_CYCLES - 1));
   assign timeout_err = r_timeout_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wdog        <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         if (r_state == S_ISSUE)     r_wdog <= '0;
         else if (r_state == S_WAIT) r_wdog <= r_wdog + 1'b1;
         if (w_timeout)              r_timeout_err <= 1'b1;
      end
   end
`else
   assign w_timeout = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lane_mem_arbiter.sv
`default_nettype none
// Testbench for lane_mem_arbiter: vector table plus multi-cycle sequences.
module tb_lane_mem_arbiter;
   localparam int NL = 4;
   localparam int AW = 7;
   localparam int DW = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [NL-1:0]    rv = '0, wv = '0;
   logic [NL*AW-1:0] ra = '0, wa = '0;
   logic [NL*DW-1:0] wd = '0;
   logic [NL-1:0]    lane_read_ack, lane_write_ack;
   logic [NL*DW-1:0] lane_read_data;
   logic             mem_read_valid, mem_write_valid, busy;
   logic [AW-1:0]    mem_read_addr, mem_write_addr;
   logic [DW-1:0]    mem_write_data;
   logic             mem_read_ready = 1'b0, mem_write_ready = 1'b0;
   logic [DW-1:0]    mem_read_data = '0;

   always #5 clk = ~clk;

   lane_mem_arbiter #(.NUM_LANES(NL), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(255)) dut (
      .clk(clk), .rst(rst),
      .lane_read_valid(rv), .lane_write_valid(wv),
      .lane_read_addr(ra), .lane_write_addr(wa), .lane_write_data(wd),
      .lane_read_ack(lane_read_ack), .lane_write_ack(lane_write_ack), .lane_read_data(lane_read_data),
      .mem_read_valid(mem_read_valid), .mem_read_addr(mem_read_addr),
      .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
      .mem_write_valid(mem_write_valid), .mem_write_addr(mem_write_addr),
      .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
      .busy(busy)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: ready 'mem_lat' cycles after valid rises (-1 = never).
   int          mem_lat = 0;
   bit          mem_auto = 0;
   logic [63:0] mem_data_fixed = '0;
   int          wait_cnt = 0;
   int          n_mem_rd = 0, n_mem_wr = 0;
   logic [6:0]  last_addr = '0;
   logic [63:0] last_wdata = '0;

   always @(posedge clk) begin
      #2;
      mem_read_ready  = 1'b0;
      mem_write_ready = 1'b0;
      if (!rst && (mem_read_valid || mem_write_valid)) begin
         if (mem_lat >= 0 && wait_cnt >= mem_lat) begin
            wait_cnt = 0;
            if (mem_read_valid) begin
               mem_read_ready = 1'b1;
               mem_read_data  = mem_auto ? 64'h1000 + 64'(mem_read_addr) : mem_data_fixed;
               last_addr      = mem_read_addr;
               n_mem_rd++;
            end else begin
               mem_write_ready = 1'b1;
               last_addr       = mem_write_addr;
               last_wdata      = mem_write_data;
               n_mem_wr++;
            end
         end else begin
            wait_cnt++;
         end
      end else begin
         wait_cnt = 0;
      end
   end

   int ack_count = 0, ack_lane = -1, ack_cyc = 0;
   bit ack_wr = 0, overlap = 0;
   int ack_q[$];

   always @(negedge clk) begin
      if (mem_read_valid && mem_write_valid) overlap = 1;
      for (int i = 0; i < NL; i++) begin
         if (lane_read_ack[i])  begin ack_count++; ack_lane = i; ack_wr = 0; ack_cyc = cyc; ack_q.push_back(i); end
         if (lane_write_ack[i]) begin ack_count++; ack_lane = i; ack_wr = 1; ack_cyc = cyc; ack_q.push_back(i); end
      end
   end

   int n_checks = 0, n_pass = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_ack(input int prev, input string name);
      int k = 0;
      while (ack_count == prev && k < 60) begin
         tick(1);
         k++;
      end
      chk(name, 64'(ack_count - prev), 64'd1);
   endtask

   typedef struct {
      int          lane;
      bit          wr;
      logic [6:0]  addr;
      logic [63:0] data;
      int          lat;
      int          exp_lat;
   } vec_t;

   vec_t        vecs[6];
   logic [63:0] exp_slot[NL];

   initial begin
      #100000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      int prev, prd, pwr, start, k;
      vecs[0] = '{2, 1'b0, 7'h15, 64'hDEADBEEF,          3, 6};
      vecs[1] = '{1, 1'b1, 7'h07, 64'd5,                 0, 3};
      vecs[2] = '{0, 1'b0, 7'h03, 64'h0123456789ABCDEF,  0, 3};
      vecs[3] = '{3, 1'b1, 7'h7F, 64'hFFFFFFFFFFFFFFFF,  1, 4};
      vecs[4] = '{3, 1'b0, 7'h00, 64'hA5A5A5A5A5A5A5A5,  2, 5};
      vecs[5] = '{1, 1'b0, 7'h40, 64'h0000000000000001,  0, 3};
      for (int i = 0; i < NL; i++) exp_slot[i] = '0;

      tick(3);
      chk("reset_busy",   64'(busy), 64'd0);
      chk("reset_rvalid", 64'(mem_read_valid), 64'd0);
      chk("reset_wvalid", 64'(mem_write_valid), 64'd0);
      chk("reset_acks",   64'({lane_read_ack, lane_write_ack}), 64'd0);
      chk("reset_rdata",  64'(|lane_read_data), 64'd0);
      rst = 1'b0;
      tick(2);

      for (int v = 0; v < 6; v++) begin
         mem_lat        = vecs[v].lat;
         mem_data_fixed = vecs[v].data;
         mem_auto       = 0;
         prev           = ack_count;
         if (vecs[v].wr) begin
            wv[vecs[v].lane] = 1'b1;
            wa[vecs[v].lane*AW +: AW] = vecs[v].addr;
            wd[vecs[v].lane*DW +: DW] = vecs[v].data;
         end else begin
            rv[vecs[v].lane] = 1'b1;
            ra[vecs[v].lane*AW +: AW] = vecs[v].addr;
            exp_slot[vecs[v].lane] = vecs[v].data;
         end
         start = cyc;
         wait_ack(prev, "vec_ack");
         rv = '0;
         wv = '0;
         chk("vec_lane",    64'(ack_lane), 64'(vecs[v].lane));
         chk("vec_kind",    64'(ack_wr), 64'(vecs[v].wr));
         chk("vec_latency", 64'(ack_cyc - start), 64'(vecs[v].exp_lat));
         chk("vec_addr",    64'(last_addr), 64'(vecs[v].addr));
         if (vecs[v].wr) chk("vec_wdata", last_wdata, vecs[v].data);
         for (int i = 0; i < NL; i++) chk("vec_slot", lane_read_data[i*DW +: DW], exp_slot[i]);
         tick(3);
      end

      // All four lanes contend right after reset.
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      ack_q.delete();
      prev     = ack_count;
      mem_lat  = 0;
      mem_auto = 1;
      for (int i = 0; i < NL; i++) begin
         rv[i] = 1'b1;
         ra[i*AW +: AW] = 7'(8*i + 1);
      end
      tick(40);
      rv = '0;
      chk("cont_acks", 64'(ack_count - prev), 64'd4);
      for (int i = 0; i < NL; i++)
         chk("cont_order", 64'((ack_q.size() > i) ? ack_q[i] : -1), 64'(i));
      for (int i = 0; i < NL; i++)
         chk("cont_slot", lane_read_data[i*DW +: DW], 64'h1000 + 64'(8*i + 1));
      chk("cont_no_overlap", 64'(overlap), 64'd0);
      tick(3);

      // Stuck write valid is served once, then again after re-arm.
      mem_auto = 0;
      prev = ack_count;
      pwr  = n_mem_wr;
      wv[1] = 1'b1;
      wa[1*AW +: AW] = 7'h07;
      wd[1*DW +: DW] = 64'd5;
      tick(25);
      chk("stuck_acks",   64'(ack_count - prev), 64'd1);
      chk("stuck_writes", 64'(n_mem_wr - pwr), 64'd1);
      wv[1] = 1'b0;
      tick(2);
      wv[1] = 1'b1;
      tick(10);
      chk("rearm_writes", 64'(n_mem_wr - pwr), 64'd2);
      chk("rearm_acks",   64'(ack_count - prev), 64'd2);
      chk("rearm_kind",   64'(ack_wr), 64'd1);
      wv = '0;
      tick(3);

      // Read and write on one lane: read first, write only after re-arm.
      prev = ack_count;
      prd  = n_mem_rd;
      pwr  = n_mem_wr;
      rv[0] = 1'b1;
      wv[0] = 1'b1;
      ra[0 +: AW] = 7'h03;
      wa[0 +: AW] = 7'h04;
      wd[0 +: DW] = 64'h77;
      tick(20);
      chk("rw_reads",  64'(n_mem_rd - prd), 64'd1);
      chk("rw_writes", 64'(n_mem_wr - pwr), 64'd0);
      chk("rw_acks",   64'(ack_count - prev), 64'd1);
      chk("rw_kind",   64'(ack_wr), 64'd0);
      chk("rw_raddr",  64'(last_addr), 64'h03);
      rv = '0;
      wv = '0;
      tick(2);
      wv[0] = 1'b1;
      tick(10);
      chk("rw_write_after", 64'(n_mem_wr - pwr), 64'd1);
      chk("rw_waddr",       64'(last_addr), 64'h04);
      chk("rw_wdata",       last_wdata, 64'h77);
      wv = '0;
      tick(3);

      // Reset while a read is pending in WAIT.
      mem_lat = -1;
      prev    = ack_count;
      rv[2]   = 1'b1;
      ra[2*AW +: AW] = 7'h2A;
      k = 0;
      while (!mem_read_valid && k < 20) begin
         tick(1);
         k++;
      end
      chk("rst_wait_valid", 64'(mem_read_valid), 64'd1);
      tick(3);
      rst = 1'b1;
      tick(1);
      chk("rst_valid", 64'(mem_read_valid), 64'd0);
      chk("rst_busy",  64'(busy), 64'd0);
      chk("rst_noack", 64'(ack_count - prev), 64'd0);
      rst            = 1'b0;
      mem_lat        = 0;
      mem_data_fixed = 64'hBEEF;
      wait_ack(prev, "rst_reserve_ack");
      rv = '0;
      chk("rst_reserve_lane", 64'(ack_lane), 64'd2);
      chk("rst_reserve_slot", lane_read_data[2*DW +: DW], 64'hBEEF);
      chk("rst_reserve_addr", 64'(last_addr), 64'h2A);
      tick(3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
